serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 cin  input  1  carry-in; captured on the accepted start.
REQ-008 busy  output  1  high while an addition is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 sum  output  WIDTH  registered result, held until the next done.
REQ-011 cout  output  1  registered carry-out, held until the next done.
REQ-012 ovf  output  1  signed overflow flag; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-013 The block SHALL compute {cout,sum} = a + b + cin, LSB first, one bit per clock.
REQ-014 Each bit SHALL be produced by one full-add cell: s = x^y^c, c_next = xy | (x^y)c, built from two half-add cells plus OR.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 IDLE, start=1 at edge k: capture a, b, cin into shift/carry registers, clear bit counter, go to RUN.
REQ-017 IDLE, start=0: remain in IDLE.
REQ-018 Each RUN edge: add operand LSBs with carry register, shift sum bit into result MSB, shift operands right, update carry, increment counter.
REQ-019 After the WIDTH-th RUN edge (edge k+WIDTH): load sum and cout from internal registers, enter DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 Latency: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH, and sum/cout valid from that cycle.
REQ-022 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; never both high together.
REQ-023 start in RUN or DONE SHALL be ignored; no queueing; operand changes during RUN SHALL not affect the result.
REQ-024 start high continuously SHALL yield back-to-back operations, one every WIDTH+2 cycles.
REQ-025 sum, cout (and ovf) SHALL change only on entry to DONE or on reset.
REQ-026 Carry out of the MSB SHALL go to cout; no wrap into the LSB; arithmetic is modulo 2^WIDTH.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, and clear busy, done, sum, cout, ovf, the counter and the internal registers to 0.
REQ-028 rst SHALL take priority over start and over any in-progress RUN; the partial result is discarded.
REQ-029 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-030 Macro SERIAL_ADDER_OVF_EN defined: port ovf exists and is loaded on entry to DONE with the carry into the MSB XOR the carry out of the MSB.
REQ-031 SERIAL_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 WIDTH=8, a=0xFF, b=0x01, cin=0, start at edge k -> done in cycle after edge k+8; sum=0x00, cout=1, ovf=0.
REQ-033 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; with macro, ovf=1.
REQ-034 a=0x55, b=0xAA, cin=1 -> sum=0x00, cout=1; busy high for exactly 8 cycles.
REQ-035 start pulsed at RUN cycle 3 with a=0x01, b=0x01 -> ignored; the first result is unchanged; exactly one done pulse.
REQ-036 rst asserted at RUN cycle 4 -> IDLE next cycle with all outputs 0 and no done; a new start with a=0x10, b=0x20 -> sum=0x30, cout=0.
REQ-037 Random a/b/cin over 1000 operations, start held high -> every result matches a+b+cin, done period = WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one full-add cell per clock, LSB first
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [1:0] ha_lo;
  logic [1:0] ha_hi;
  logic       bit_s;
  logic       bit_c;

  // Half-add cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-add cell on the operand LSBs and the running carry, built from two half-adds plus OR.
  always_comb begin
    ha_lo = half_add(a_q[0], b_q[0]);
    ha_hi = half_add(ha_lo[0], carry_q);
    bit_s = ha_hi[0];
    bit_c = ha_lo[1] | ha_hi[1];
  end

  // Next-state and datapath updates; result registers only move on the final RUN edge.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // The last bit is still combinational here, so fold it in directly.
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this edge.
          ovf_d   = carry_q ^ bit_c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status flags decode straight from the registered state, so they are mutually exclusive.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder against an arithmetic model
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int sx, sy, s;
    sx = (x[W-1]) ? int'(x) - (1 << W) : int'(x);
    sy = (y[W-1]) ? int'(y) - (1 << W) : int'(y);
    s  = sx + sy + int'(c);
    return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
  endfunction

  function automatic logic get_ovf;
`ifdef SERIAL_ADDER_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        output logic [W-1:0] s, output logic co, output logic ov,
                        output int lat, output int busy_cnt, output int both_cnt);
    a = x; b = y; cin = c; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0; busy_cnt = 0; both_cnt = 0;
    while (!done && lat < 3*W) begin
      if (busy) busy_cnt++;
      tick;
      lat++;
    end
    if (busy && done) both_cnt++;
    s = sum; co = cout; ov = get_ovf();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
  endtask

  task automatic test_vectors;
    logic [W-1:0] va[3] = '{8'hFF, 8'h7F, 8'h55};
    logic [W-1:0] vb[3] = '{8'h01, 8'h01, 8'hAA};
    logic         vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] s;
    logic co, ov;
    logic [W:0] exp;
    int lat, bc, both;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], s, co, ov, lat, bc, both);
      exp = ref_add(va[i], vb[i], vc[i]);
      checks++; if (s !== exp[W-1:0]) begin errors++; $display("FAIL vec%0d_sum got %h want %h", i, s, exp[W-1:0]); end
      checks++; if (co !== exp[W]) begin errors++; $display("FAIL vec%0d_cout got %b want %b", i, co, exp[W]); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (ov !== ref_ovf(va[i], vb[i], vc[i])) begin errors++; $display("FAIL vec%0d_ovf got %b want %b", i, ov, ref_ovf(va[i], vb[i], vc[i])); end
`endif
      checks++; if (lat !== W) begin errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, W); end
      checks++; if (bc !== W) begin errors++; $display("FAIL vec%0d_busy_cycles got %0d want %0d", i, bc, W); end
      checks++; if (both !== 0) begin errors++; $display("FAIL vec%0d_busy_and_done got %0d want 0", i, both); end
      tick;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL vec%0d_done_width got done=%b busy=%b want 0 0", i, done, busy); end
    end
  endtask

  task automatic test_start_ignored;
    int lat, dones;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 3; dones = 0;
    while (!done && lat < 3*W) begin
      a = W'($urandom); b = W'($urandom); cin = 1'(($urandom));
      tick;
      lat++;
    end
    checks++; if (sum !== 8'h46 || cout !== 1'b0) begin errors++; $display("FAIL ignore_start_result got %h/%b want 46/0", sum, cout); end
    checks++; if (lat !== W) begin errors++; $display("FAIL ignore_start_latency got %0d want %0d", lat, W); end
    if (done) dones++;
    for (int i = 0; i < 2*W; i++) begin
      tick;
      if (done) dones++;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_start_done_pulses got %0d want 1", dones); end
  endtask

  task automatic test_reset_midrun;
    logic [W-1:0] s;
    logic co, ov;
    int lat, bc, both, dones;
    a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrun_reset_flags got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (sum !== '0 || cout !== 1'b0 || get_ovf() !== 1'b0) begin errors++; $display("FAIL midrun_reset_outputs got %h/%b/%b want 00/0/0", sum, cout, get_ovf()); end
    dones = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick;
      if (done || busy) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrun_reset_activity got %0d want 0", dones); end
    run_op(8'h10, 8'h20, 1'b0, s, co, ov, lat, bc, both);
    checks++; if (s !== 8'h30 || co !== 1'b0) begin errors++; $display("FAIL after_reset_result got %h/%b want 30/0", s, co); end
    checks++; if (lat !== W) begin errors++; $display("FAIL after_reset_latency got %0d want %0d", lat, W); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ha[16];
    logic [W-1:0] hb[16];
    logic         hc[16];
    logic [W:0]   exp;
    int n, ops, prev, idx, bad_res, bad_per, limit;
    n = 0; ops = 0; prev = -1; bad_res = 0; bad_per = 0;
    limit = 1000 * (W + 2) + 50;
    start = 1'b1;
    while (ops < 1000 && n < limit) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      ha[n % 16] = a; hb[n % 16] = b; hc[n % 16] = cin;
      tick;
      if (done) begin
        idx = (n - W) % 16;
        exp = ref_add(ha[idx], hb[idx], hc[idx]);
        checks++;
        if (sum !== exp[W-1:0] || cout !== exp[W]
`ifdef SERIAL_ADDER_OVF_EN
            || ovf !== ref_ovf(ha[idx], hb[idx], hc[idx])
`endif
           ) begin
          errors++; bad_res++;
          if (bad_res <= 5) $display("FAIL b2b_result op %0d got %h/%b want %h/%b", ops, sum, cout, exp[W-1:0], exp[W]);
        end
        if (prev >= 0) begin
          checks++;
          if (n - prev !== W + 2) begin
            errors++; bad_per++;
            if (bad_per <= 5) $display("FAIL b2b_period op %0d got %0d want %0d", ops, n - prev, W + 2);
          end
        end
        prev = n;
        ops++;
      end
      n++;
    end
    start = 1'b0;
    checks++; if (ops !== 1000) begin errors++; $display("FAIL b2b_op_count got %0d want 1000", ops); end
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_start_ignored;
    test_reset_midrun;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
